// File: rtl/gpr_file.sv
// Two-read, one-write register file with registered read ports and synchronous clear.
// Define GPR_FILE_BYPASS_EN to forward same-edge write data to a matching read.
module gpr_file #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             clr,
  input  logic             rd0_en,
  input  logic [AW-1:0]    rd0_addr,
  input  logic             rd1_en,
  input  logic [AW-1:0]    rd1_addr,
  output logic [WIDTH-1:0] rd0_data,
  output logic [WIDTH-1:0] rd1_data,
  output logic             rd0_valid,
  output logic             rd1_valid
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [WIDTH-1:0] rd0_data_q, rd0_data_d;
  logic [WIDTH-1:0] rd1_data_q, rd1_data_d;
  logic             rd0_valid_q, rd1_valid_q;
  logic [WIDTH-1:0] rd0_val, rd1_val;

  // clr wins over a write at the same edge; the write is simply lost.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) regs_d[i] = regs_q[i];
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) regs_d[i] = '0;
    end else if (wr_en) begin
      regs_d[wr_addr] = wr_data;
    end
  end

`ifdef GPR_FILE_BYPASS_EN
  logic wr_live;
  assign wr_live = wr_en & ~clr;
  assign rd0_val = (wr_live && (rd0_addr == wr_addr)) ? wr_data : regs_q[rd0_addr];
  assign rd1_val = (wr_live && (rd1_addr == wr_addr)) ? wr_data : regs_q[rd1_addr];
`else
  assign rd0_val = regs_q[rd0_addr];
  assign rd1_val = regs_q[rd1_addr];
`endif

  // Read handshake: rdN_en sampled at an edge yields rdN_valid=1 for exactly the
  // following cycle with rdN_data; with no request valid drops and data holds.
  always_comb begin
    rd0_data_d = rd0_en ? rd0_val : rd0_data_q;
    rd1_data_d = rd1_en ? rd1_val : rd1_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      rd0_data_q  <= '0;
      rd1_data_q  <= '0;
      rd0_valid_q <= 1'b0;
      rd1_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
      rd0_data_q  <= rd0_data_d;
      rd1_data_q  <= rd1_data_d;
      rd0_valid_q <= rd0_en;
      rd1_valid_q <= rd1_en;
    end
  end

  assign rd0_data  = rd0_data_q;
  assign rd1_data  = rd1_data_q;
  assign rd0_valid = rd0_valid_q;
  assign rd1_valid = rd1_valid_q;

endmodule

// File: tb/tb_gpr_file.sv
// Self-checking bench for gpr_file: reference model plus per-port expected queues.
module tb_gpr_file;
  localparam int WIDTH = 24;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wr_en, clr, rd0_en, rd1_en;
  logic [AW-1:0]    wr_addr, rd0_addr, rd1_addr;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] rd0_data, rd1_data;
  logic             rd0_valid, rd1_valid;

  gpr_file #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .clr(clr),
    .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd1_en(rd1_en), .rd1_addr(rd1_addr),
    .rd0_data(rd0_data), .rd1_data(rd1_data),
    .rd0_valid(rd0_valid), .rd1_valid(rd1_valid)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  string phase = "init";

  logic [WIDTH-1:0] model [DEPTH];
  logic [WIDTH-1:0] exp0_q[$];
  logic [WIDTH-1:0] exp1_q[$];
  logic             pend0, pend1;
  logic [WIDTH-1:0] last0, last1;

  task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s/%s got=%h exp=%h", phase, tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] model_read(input logic [AW-1:0] a);
`ifdef GPR_FILE_BYPASS_EN
    if (wr_en && !clr && (a == wr_addr)) return wr_data;
`endif
    return model[a];
  endfunction

  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [WIDTH-1:0] wd,
                       input logic c, input logic r0e, input logic [AW-1:0] r0a,
                       input logic r1e, input logic [AW-1:0] r1a);
    wr_en = we; wr_addr = wa; wr_data = wd; clr = c;
    rd0_en = r0e; rd0_addr = r0a; rd1_en = r1e; rd1_addr = r1a;
  endtask

  // Push expectations for the current inputs, advance the model, then check after the edge.
  task automatic tick();
    logic [WIDTH-1:0] e;
    if (rd0_en) exp0_q.push_back(model_read(rd0_addr));
    if (rd1_en) exp1_q.push_back(model_read(rd1_addr));
    pend0 = rd0_en;
    pend1 = rd1_en;
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
    end else if (wr_en) begin
      model[wr_addr] = wr_data;
    end
    @(posedge clk);
    #1;
    check("rd0_valid", {23'd0, rd0_valid}, {23'd0, pend0});
    if (pend0 && exp0_q.size() > 0) begin
      e = exp0_q.pop_front();
      last0 = e;
    end
    check("rd0_data", rd0_data, last0);
    check("rd1_valid", {23'd0, rd1_valid}, {23'd0, pend1});
    if (pend1 && exp1_q.size() > 0) begin
      e = exp1_q.pop_front();
      last1 = e;
    end
    check("rd1_data", rd1_data, last1);
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    exp0_q.delete();
    exp1_q.delete();
    pend0 = 1'b0; pend1 = 1'b0;
    last0 = '0;   last1 = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #1;
    phase = "reset";
    check("rd0_data", rd0_data, '0);
    check("rd1_data", rd1_data, '0);
    check("rd0_valid", {23'd0, rd0_valid}, '0);
    check("rd1_valid", {23'd0, rd1_valid}, '0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    phase = "wr_rd_basic";
    drive(1, 3, 24'd100, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 3, 0, 0);       tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);       tick();

    phase = "dual_port";
    drive(1, 2, 24'hABCDEF, 0, 0, 0, 0, 0); tick();
    drive(1, 5, 24'h000001, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 2, 1, 5);          tick();
    drive(0, 0, 0, 0, 1, 5, 1, 5);          tick();

    phase = "same_edge_wr_rd";
    drive(1, 4, 24'd7, 0, 0, 0, 0, 0); tick();
    drive(1, 4, 24'd9, 0, 1, 4, 1, 4); tick();
    drive(0, 0, 0, 0, 1, 4, 0, 0);     tick();

    phase = "clear";
    for (int a = 0; a < DEPTH; a++) begin
      drive(1, AW'(a), 24'hFFFFFF, 0, 0, 0, 0, 0); tick();
    end
    drive(1, 1, 24'd5, 1, 1, 1, 1, 6); tick();
    for (int a = 0; a < DEPTH; a++) begin
      drive(0, 0, 0, 0, 1, AW'(a), 1, AW'(DEPTH - 1 - a)); tick();
    end

    phase = "random";
    for (int n = 0; n < 60; n++) begin
      drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)),
            WIDTH'($urandom_range(0, 32'hFFFFFF)), ($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)),
            1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)));
      tick();
    end

    phase = "reset_mid_read";
    drive(1, 3, 24'h123456, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 3, 1, 3);          tick();
    drive(0, 0, 0, 0, 1, 3, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rd0_valid_async", {23'd0, rd0_valid}, '0);
    check("rd0_data_async", rd0_data, '0);
    check("rd1_data_async", rd1_data, '0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    tick();
    drive(0, 0, 0, 0, 1, 3, 1, 2); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
